// File: rtl/ac97_pkg.sv
// rtl/ac97_pkg.sv - AC97 frame constants and framing state shared by the receiver and transmitter
package ac97_pkg;

  localparam int FRAME_BITS  = 256;
  localparam int TAG_BITS    = 16;
  localparam int SLOT_BITS   = 20;
  localparam int SLOT1_START = 16;
  localparam int SLOT2_START = 36;
  localparam int SLOT3_START = 56;
  localparam int SLOT4_START = 76;

  typedef enum logic {
    HUNT,
    FRAME
  } ac97_state_t;

  // True while cnt lies in the window [start, start+len); all windows end at or below bit 96
  function automatic logic in_window(input logic [7:0] cnt, input logic [7:0] start,
                                     input logic [7:0] len);
    return (cnt >= start) && (cnt < start + len);
  endfunction

endpackage

// File: rtl/ac97_slot_shift.sv
// rtl/ac97_slot_shift.sv - 20-bit MSB-first slot shift register
module ac97_slot_shift
  import ac97_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_en,
  input  logic                 sdata,
  output logic [SLOT_BITS-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else if (shift_en) begin
      data <= {data[SLOT_BITS-2:0], sdata};
    end
  end

endmodule

// File: rtl/ac97_frame_receiver.sv
// rtl/ac97_frame_receiver.sv - AC97 codec-to-controller frame deserializer
// Extracts tag, codec status (slots 1/2) and record PCM (slots 3/4) with one-cycle valid pulses.
module ac97_frame_receiver
  import ac97_pkg::*;
#(
  parameter int PCM_WIDTH = 16
) (
  input  logic                 ac97_bitclk,
  input  logic                 reset,
  input  logic                 ac97_sync,
  input  logic                 ac97_sdata_in,
  output logic                 codec_ready,
  output logic                 status_valid,
  output logic [6:0]           status_addr,
  output logic [15:0]          status_data,
  output logic                 pcm_valid,
  output logic [PCM_WIDTH-1:0] pcm_left,
  output logic [PCM_WIDTH-1:0] pcm_right,
  output logic                 frame_error,
  output logic                 locked
);

  ac97_state_t          state, state_next;
  logic                 sync_q;
  logic                 sync_rise;
  logic [7:0]           bit_cnt, cnt_next;
  logic [TAG_BITS-1:0]  tag;
  logic [SLOT_BITS-1:0] slot1, slot2, slot3, slot4;
  logic                 in_frame, last_bit, commit, err;
  logic                 tag_en;
  logic [3:0]           slot_en;
  logic                 unused_slot_bits;

  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    commit     = 1'b0;
    err        = 1'b0;
    sync_rise  = ac97_sync & ~sync_q;
    in_frame   = (state == FRAME);
    last_bit   = in_frame && (bit_cnt == 8'(FRAME_BITS - 1));
    tag_en     = in_frame && in_window(bit_cnt, 8'd0, 8'(TAG_BITS));
    slot_en[0] = in_frame && in_window(bit_cnt, 8'(SLOT1_START), 8'(SLOT_BITS));
    slot_en[1] = in_frame && in_window(bit_cnt, 8'(SLOT2_START), 8'(SLOT_BITS));
    slot_en[2] = in_frame && in_window(bit_cnt, 8'(SLOT3_START), 8'(SLOT_BITS));
    slot_en[3] = in_frame && in_window(bit_cnt, 8'(SLOT4_START), 8'(SLOT_BITS));
    case (state)
      HUNT: begin
        if (sync_rise) begin
          state_next = FRAME;
          cnt_next   = '0;
        end
      end
      FRAME: begin
        if (last_bit) begin
          // A complete frame commits whether or not the next sync arrives on time
          commit   = 1'b1;
          cnt_next = '0;
          if (!sync_rise) begin
            err        = 1'b1;
            state_next = HUNT;
          end
        end else if (sync_rise) begin
          err      = 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next = bit_cnt + 8'd1;
        end
      end
      default: begin
        state_next = HUNT;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge ac97_bitclk) begin
    if (reset) begin
      state   <= HUNT;
      sync_q  <= 1'b0;
      bit_cnt <= '0;
      tag     <= '0;
    end else begin
      state   <= state_next;
      sync_q  <= ac97_sync;
      bit_cnt <= cnt_next;
      if (tag_en) tag <= {tag[TAG_BITS-2:0], ac97_sdata_in};
    end
  end

  ac97_slot_shift u_slot1 (.clk(ac97_bitclk), .reset(reset), .shift_en(slot_en[0]), .sdata(ac97_sdata_in), .data(slot1));
  ac97_slot_shift u_slot2 (.clk(ac97_bitclk), .reset(reset), .shift_en(slot_en[1]), .sdata(ac97_sdata_in), .data(slot2));
  ac97_slot_shift u_slot3 (.clk(ac97_bitclk), .reset(reset), .shift_en(slot_en[2]), .sdata(ac97_sdata_in), .data(slot3));
  ac97_slot_shift u_slot4 (.clk(ac97_bitclk), .reset(reset), .shift_en(slot_en[3]), .sdata(ac97_sdata_in), .data(slot4));

  // Reserved and truncated slot bits are intentionally dropped
  assign unused_slot_bits = ^{slot1[19], slot1[11:0], slot2[3:0], slot3, slot4};

  always_ff @(posedge ac97_bitclk) begin
    if (reset) begin
      codec_ready  <= 1'b0;
      status_valid <= 1'b0;
      status_addr  <= '0;
      status_data  <= '0;
      pcm_valid    <= 1'b0;
      pcm_left     <= '0;
      pcm_right    <= '0;
      frame_error  <= 1'b0;
      locked       <= 1'b0;
    end else begin
      status_valid <= 1'b0;
      pcm_valid    <= 1'b0;
      frame_error  <= err;
      locked       <= (state_next == FRAME);
      if (commit) begin
        codec_ready <= tag[15];
        if (tag[15] & tag[14] & tag[13]) begin
          status_valid <= 1'b1;
          status_addr  <= slot1[18:12];
          status_data  <= slot2[19:4];
        end
        if (tag[15] & tag[12] & tag[11]) begin
          pcm_valid <= 1'b1;
          pcm_left  <= slot3[SLOT_BITS-1 -: PCM_WIDTH];
          pcm_right <= slot4[SLOT_BITS-1 -: PCM_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_ac97_frame_receiver.sv
// tb/tb_ac97_frame_receiver.sv - directed table-driven bench for ac97_frame_receiver
module tb_ac97_frame_receiver;

  logic        ac97_bitclk = 1'b0;
  logic        reset;
  logic        ac97_sync;
  logic        ac97_sdata_in;
  logic        codec_ready, status_valid, pcm_valid, frame_error, locked;
  logic [6:0]  status_addr;
  logic [15:0] status_data, pcm_left, pcm_right;

  ac97_frame_receiver #(.PCM_WIDTH(16)) dut (
    .ac97_bitclk   (ac97_bitclk),
    .reset         (reset),
    .ac97_sync     (ac97_sync),
    .ac97_sdata_in (ac97_sdata_in),
    .codec_ready   (codec_ready),
    .status_valid  (status_valid),
    .status_addr   (status_addr),
    .status_data   (status_data),
    .pcm_valid     (pcm_valid),
    .pcm_left      (pcm_left),
    .pcm_right     (pcm_right),
    .frame_error   (frame_error),
    .locked        (locked)
  );

  always #5 ac97_bitclk = ~ac97_bitclk;

  typedef struct {
    logic [15:0] tag;
    logic [19:0] s1, s2, s3, s4;
    int          ns, np, ne;
    logic        rdy, lck;
    logic [6:0]  addr;
    logic [15:0] data, left, right;
  } frame_vec_t;

  frame_vec_t vecs [9];
  int checks = 0;
  int errors = 0;
  int n_sv, n_pv, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the next falling edge
  task automatic drive_bit(input logic s, input logic d);
    ac97_sync     = s;
    ac97_sdata_in = d;
    @(negedge ac97_bitclk);
    if (status_valid) n_sv++;
    if (pcm_valid) n_pv++;
    if (frame_error) n_err++;
  endtask

  function automatic logic [255:0] build_frame(input frame_vec_t v);
    logic [255:0] f;
    f = '0;
    for (int i = 96; i < 256; i++) f[i] = 1'($urandom);
    for (int i = 0; i < 16; i++) f[i] = v.tag[15-i];
    for (int j = 0; j < 20; j++) begin
      f[16+j] = v.s1[19-j];
      f[36+j] = v.s2[19-j];
      f[56+j] = v.s3[19-j];
      f[76+j] = v.s4[19-j];
    end
    return f;
  endfunction

  // Sync is held high over bits 0..14; the final bit optionally carries the next sync rise
  task automatic drive_frame(input logic [255:0] f, input int nbits, input logic sync_last);
    n_sv = 0; n_pv = 0; n_err = 0;
    for (int i = 0; i < nbits; i++)
      drive_bit((i < 15) || ((i == nbits - 1) && sync_last), f[i]);
  endtask

  task automatic check_frame(input frame_vec_t v, input int idx);
    string p;
    p = $sformatf("f%0d_", idx);
    chk({p, "sv_count"}, n_sv, v.ns);
    chk({p, "pv_count"}, n_pv, v.np);
    chk({p, "err_count"}, n_err, v.ne);
    chk({p, "sv_now"}, status_valid, (v.ns != 0));
    chk({p, "err_now"}, frame_error, (v.ne != 0));
    chk({p, "ready"}, codec_ready, v.rdy);
    chk({p, "locked"}, locked, v.lck);
    chk({p, "addr"}, status_addr, v.addr);
    chk({p, "data"}, status_data, v.data);
    chk({p, "left"}, pcm_left, v.left);
    chk({p, "right"}, pcm_right, v.right);
  endtask

  task automatic check_zero(input string p);
    chk({p, "ready"}, codec_ready, 0);
    chk({p, "sv"}, status_valid, 0);
    chk({p, "addr"}, status_addr, 0);
    chk({p, "data"}, status_data, 0);
    chk({p, "pv"}, pcm_valid, 0);
    chk({p, "left"}, pcm_left, 0);
    chk({p, "right"}, pcm_right, 0);
    chk({p, "err"}, frame_error, 0);
    chk({p, "locked"}, locked, 0);
  endtask

  initial begin
    //             tag       s1          s2          s3          s4        ns np ne rdy   lck   addr   data      left      right
    vecs[0] = '{16'hF800, 20'h26000, 20'h000F0, 20'hABCDE, 20'h12345, 1, 1, 0, 1'b1, 1'b1, 7'h26, 16'h000F, 16'hABCD, 16'h1234};
    vecs[1] = '{16'h9800, 20'h7F000, 20'hFFFF0, 20'h55555, 20'hAAAAA, 0, 1, 0, 1'b1, 1'b1, 7'h26, 16'h000F, 16'h5555, 16'hAAAA};
    vecs[2] = '{16'h7800, 20'h3C000, 20'h77770, 20'h99999, 20'h66666, 0, 0, 0, 1'b0, 1'b1, 7'h26, 16'h000F, 16'h5555, 16'hAAAA};
    vecs[3] = '{16'hE000, 20'h01000, 20'h12340, 20'hFFFFF, 20'hFFFFF, 1, 0, 0, 1'b1, 1'b1, 7'h01, 16'h1234, 16'h5555, 16'hAAAA};
    vecs[4] = '{16'hF800, 20'h7E000, 20'hBEEF0, 20'h80001, 20'h0000F, 1, 1, 0, 1'b1, 1'b1, 7'h7E, 16'hBEEF, 16'h8000, 16'h0000};
    vecs[5] = '{16'hF800, 20'h11000, 20'h99990, 20'h33333, 20'h44444, 0, 0, 1, 1'b1, 1'b1, 7'h7E, 16'hBEEF, 16'h8000, 16'h0000};
    vecs[6] = '{16'hF800, 20'h05000, 20'hCAFE0, 20'h13579, 20'h2468A, 1, 1, 0, 1'b1, 1'b1, 7'h05, 16'hCAFE, 16'h1357, 16'h2468};
    vecs[7] = '{16'hF800, 20'h40000, 20'h00010, 20'hFFFF0, 20'h00000, 1, 1, 1, 1'b1, 1'b0, 7'h40, 16'h0001, 16'hFFFF, 16'h0000};
    vecs[8] = '{16'hF800, 20'h26000, 20'h000F0, 20'hABCDE, 20'h12345, 1, 1, 0, 1'b1, 1'b1, 7'h26, 16'h000F, 16'hABCD, 16'h1234};

    reset = 1'b1; ac97_sync = 1'b0; ac97_sdata_in = 1'b0;
    repeat (3) @(negedge ac97_bitclk);
    check_zero("reset_");
    reset = 1'b0;

    drive_bit(1'b1, 1'b0);
    chk("lock_rise", locked, 1);
    for (int k = 0; k < 5; k++) begin
      drive_frame(build_frame(vecs[k]), 256, 1'b1);
      check_frame(vecs[k], k);
    end

    // Early sync at bit 100: error pulse, partial frame discarded
    drive_frame(build_frame(vecs[5]), 101, 1'b1);
    check_frame(vecs[5], 5);
    drive_frame(build_frame(vecs[6]), 256, 1'b1);
    check_frame(vecs[6], 6);

    // Missing sync after bit 255: commit plus error, then idle in HUNT
    drive_frame(build_frame(vecs[7]), 256, 1'b0);
    check_frame(vecs[7], 7);
    n_sv = 0; n_pv = 0; n_err = 0;
    for (int i = 0; i < 40; i++) drive_bit(1'b0, 1'($urandom));
    chk("hunt_sv", n_sv, 0);
    chk("hunt_pv", n_pv, 0);
    chk("hunt_err", n_err, 0);
    chk("hunt_locked", locked, 0);

    // Reset at bit 60 of a frame, then a clean frame
    drive_bit(1'b1, 1'b0);
    drive_frame(build_frame(vecs[8]), 60, 1'b0);
    reset = 1'b1;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    check_zero("midreset_");
    reset = 1'b0;
    drive_bit(1'b1, 1'b0);
    drive_frame(build_frame(vecs[8]), 256, 1'b1);
    check_frame(vecs[8], 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ac97_frame_receiver.md
# ac97_frame_receiver

Deserializes the AC97 codec-to-controller stream (`ac97_sdata_in`), framed by the controller's own `ac97_sync`, on `ac97_bitclk`. Extracts the slot-0 tag, the slot-1/2 codec status (register read-back address/data) and the slot-3/4 record PCM samples. Presents them as registered outputs with single-cycle valid pulses. It sits beside the AC97 transmitter in the sound subsystem and gives the design codec register read-back and a record path.

## Interface
- `PCM_WIDTH`, default 16: MSBs of each 20-bit PCM slot kept; legal 1..20.
- `ac97_bitclk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `ac97_sync` input 1: frame sync as driven to the codec (high during slot 0).
- `ac97_sdata_in` input 1: serial data from the codec, MSB first.
- `codec_ready` output 1: tag bit 15 of the last completed frame.
- `status_valid` output 1: one-cycle pulse; `status_addr`/`status_data` were updated.
- `status_addr` output 7: slot-1 bits 18:12.
- `status_data` output 16: slot-2 bits 19:4.
- `pcm_valid` output 1: one-cycle pulse; `pcm_left`/`pcm_right` were updated.
- `pcm_left` output PCM_WIDTH: slot-3 bits 19:(20-PCM_WIDTH).
- `pcm_right` output PCM_WIDTH: slot-4 bits 19:(20-PCM_WIDTH).
- `frame_error` output 1: one-cycle pulse on a sync/framing violation.
- `locked` output 1: high while in state FRAME.

## Operation
- Sync rise: `ac97_sync`=1 this cycle and registered `sync_q`=0.
- Sync rise detected in cycle T means the `ac97_sdata_in` sample at cycle T+1 is frame bit 0 (tag bit 15).
- Frame layout is 256 bits. Tag is bits 0..15, tag[15-i] at bit i. Slot k (1..12) occupies bits 16+20(k-1) .. 35+20(k-1), MSB first.
- Slots 1..4 are at bits 16..35, 36..55, 56..75 and 76..95. Bits 96..255 are counted and discarded.
- State HUNT:
  - `bit_cnt` is idle and nothing is committed.
  - On a sync rise, load `bit_cnt`=0 for the next cycle and go to FRAME.
- State FRAME: each cycle, shift `ac97_sdata_in` into the tag register or the current slot register, then increment the 8-bit `bit_cnt`.
- Commit happens in the cycle where bit 255 is sampled; outputs update at the following edge.
  - `codec_ready` <= tag[15].
  - If tag[15]&tag[14]&tag[13]: load `status_addr`/`status_data` and pulse `status_valid`. Otherwise they hold.
  - If tag[15]&tag[12]&tag[11]: load `pcm_left`/`pcm_right` and pulse `pcm_valid`. Otherwise they hold.
- Sync rise in the same cycle as bit 255 is a normal back-to-back frame: commit, then `bit_cnt`=0 next cycle, stay in FRAME.
- Sync rise in FRAME with `bit_cnt`≠255:
  - pulse `frame_error`, discard the partial frame with no commit;
  - restart with `bit_cnt`=0 next cycle and stay in FRAME.
- Bit 255 sampled with no sync rise: commit the completed frame, pulse `frame_error` in the same cycle as the valid pulses, and go to HUNT.
- Reset mid-frame discards everything and enters HUNT. No commit or pulse is produced for the aborted frame.

## Timing
- Reset values: all outputs 0, state HUNT, `sync_q`=0, `bit_cnt`=0.
- All outputs are registered.
- Latency: last sampled bit (255) to `status_valid`/`pcm_valid` high is 1 cycle.
- Pulses are exactly 1 cycle wide, at most one of each per frame.
- Data outputs are stable from their valid pulse until the next qualifying commit.
- `locked` rises one cycle after the sync rise that leaves HUNT. It falls one cycle after bit 255 when no sync accompanies it.
- No back-pressure: the consumer must take the data within 256 cycles.

## Structure
- Shared package `ac97_pkg`:
  - constants `FRAME_BITS`=256, `TAG_BITS`=16, `SLOT_BITS`=20;
  - slot start offsets `SLOT1_START`=16, `SLOT2_START`=36, `SLOT3_START`=56, `SLOT4_START`=76;
  - state enum {HUNT, FRAME}.
- The same package serves the transmitter.
- One sub-module, `ac97_slot_shift`: a 20-bit MSB-first shift register with `shift_en`, shared by slots 1..4 (four instances). The tag uses a 16-bit shift register inline.

## Test plan
- Reset, then one frame: tag 0xF800, slot1 addr 7'h26, slot2 0x000F, slot3 0xABCDE, slot4 0x12345, then the next sync at bit 255 -> one cycle after bit 255: `status_valid`=1, `status_addr`=7'h26, `status_data`=0x000F, `pcm_valid`=1, `pcm_left`=0xABCD, `pcm_right`=0x1234, `codec_ready`=1, `frame_error`=0.
- Tag 0x9800 (slot-1/2 valid bits clear) -> `pcm_valid` pulse only; `status_*` hold their previous values.
- Tag 0x7800 (codec not ready) -> no valid pulses, `codec_ready`=0.
- Sync rise at bit 100 -> `frame_error` pulse one cycle later, no commit; the next clean 256-bit frame commits normally.
- Sync absent after bit 255 -> commit plus `frame_error` pulse, `locked`=0, no further pulses until the next sync rise.
- Assert `reset` at bit 60 -> all outputs 0, HUNT; the first frame after reset is decoded correctly.
